// File: rtl/tcb_argmax_seq_pkg.sv
// Shared state type and score-extension helper for the sequential TCB argmax stage.
package tcb_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int N_CLASS_DEF = 10;
  localparam int IDX_W       = $clog2(N_CLASS_DEF);
  localparam int SCORE_W_MAX = 64;

  // Sign- or zero-extends the low 'width' bits of val across the full word.
  function automatic logic [SCORE_W_MAX:0] extend_score(
    input logic [SCORE_W_MAX-1:0] val,
    input int                     width,
    input logic                   signed_flag
  );
    logic [SCORE_W_MAX:0] hi_mask;
    logic                 msb;
    hi_mask = {(SCORE_W_MAX+1){1'b1}} << width;
    msb     = |(val & (SCORE_W_MAX'(1) << (width - 1)));
    return ({1'b0, val} & ~hi_mask) | ({(SCORE_W_MAX+1){signed_flag & msb}} & hi_mask);
  endfunction

endpackage

// File: rtl/tcb_argmax_seq_score_cmp.sv
// Combinational strict greater-than for one score pair, signed or unsigned.
module tcb_score_cmp
  import tcb_pkg::*;
#(
  parameter int SCORE_W      = 27,
  parameter bit SCORE_SIGNED = 1'b1
) (
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               gt
);

  logic [SCORE_W_MAX:0] w_a_ext;
  logic [SCORE_W_MAX:0] w_b_ext;

  assign w_a_ext = extend_score(SCORE_W_MAX'(a), SCORE_W, SCORE_SIGNED);
  assign w_b_ext = extend_score(SCORE_W_MAX'(b), SCORE_W, SCORE_SIGNED);

  // Unsigned inputs arrive zero-extended, so a signed compare covers both modes.
  assign gt = $signed(w_a_ext) > $signed(w_b_ext);

endmodule

// File: rtl/tcb_argmax_seq.sv
// Sequential argmax over N_CLASS scores, one class per cycle, with drop counting.
// Define TCB_ARGMAX_TOP2_EN to add second-best index (predict2) and margin outputs.
//
// state | meaning
// IDLE  | waiting for valid
// SCAN  | comparing classes 1..N_CLASS-1 against the running best
// DONE  | result registered, ready high for this one cycle; accepts a new valid
module tcb_argmax_seq
  import tcb_pkg::*;
#(
  parameter int N_CLASS      = 10,
  parameter int SCORE_W      = 27,
  parameter bit SCORE_SIGNED = 1'b1,
  parameter int DROP_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CLASS*SCORE_W-1:0] layer_out,
  input  logic                       valid,
  output logic [31:0]                predict,
  output logic                       ready,
  output logic                       busy,
  output logic [DROP_W-1:0]          drop_cnt
`ifdef TCB_ARGMAX_TOP2_EN
  ,
  output logic [31:0]                predict2,
  output logic [SCORE_W:0]           margin
`endif
);

  localparam int              CNT_W    = $clog2(N_CLASS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASS - 1);

  state_t             r_state;
  logic [SCORE_W-1:0] r_score [N_CLASS];
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_best_idx;
  logic [SCORE_W-1:0] r_best_val;

  logic [SCORE_W-1:0] w_cur;
  logic               w_gt_best;
  logic [CNT_W-1:0]   w_best_idx_nx;
  logic [SCORE_W-1:0] w_best_val_nx;

  assign w_cur = r_score[r_idx];

  tcb_score_cmp #(
    .SCORE_W      (SCORE_W),
    .SCORE_SIGNED (SCORE_SIGNED)
  ) u_cmp_best (
    .a  (w_cur),
    .b  (r_best_val),
    .gt (w_gt_best)
  );

  // Strict compare keeps the lower index on ties.
  assign w_best_idx_nx = w_gt_best ? r_idx : r_best_idx;
  assign w_best_val_nx = w_gt_best ? w_cur : r_best_val;

`ifdef TCB_ARGMAX_TOP2_EN
  logic [CNT_W-1:0]   r_sec_idx;
  logic [SCORE_W-1:0] r_sec_val;
  logic               r_sec_full;
  logic               w_gt_sec;
  logic [CNT_W-1:0]   w_sec_idx_nx;
  logic [SCORE_W-1:0] w_sec_val_nx;
  logic [SCORE_W:0]   w_best_ext;
  logic [SCORE_W:0]   w_sec_ext;

  tcb_score_cmp #(
    .SCORE_W      (SCORE_W),
    .SCORE_SIGNED (SCORE_SIGNED)
  ) u_cmp_sec (
    .a  (w_cur),
    .b  (r_sec_val),
    .gt (w_gt_sec)
  );

  always_comb begin
    w_sec_idx_nx = r_sec_idx;
    w_sec_val_nx = r_sec_val;
    if (w_gt_best) begin
      w_sec_idx_nx = r_best_idx;
      w_sec_val_nx = r_best_val;
    end else if (!r_sec_full || w_gt_sec) begin
      w_sec_idx_nx = r_idx;
      w_sec_val_nx = w_cur;
    end
  end

  assign w_best_ext = {SCORE_SIGNED & w_best_val_nx[SCORE_W-1], w_best_val_nx};
  assign w_sec_ext  = {SCORE_SIGNED & w_sec_val_nx[SCORE_W-1], w_sec_val_nx};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      predict    <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
`ifdef TCB_ARGMAX_TOP2_EN
      r_sec_idx  <= '0;
      r_sec_val  <= '0;
      r_sec_full <= 1'b0;
      predict2   <= '0;
      margin     <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (valid) begin
            for (int k = 0; k < N_CLASS; k++) begin
              r_score[k] <= layer_out[k*SCORE_W +: SCORE_W];
            end
            r_best_val <= layer_out[SCORE_W-1:0];
            r_best_idx <= '0;
            r_idx      <= CNT_W'(1);
            busy       <= 1'b1;
            r_state    <= SCAN;
`ifdef TCB_ARGMAX_TOP2_EN
            r_sec_val  <= layer_out[SCORE_W-1:0];
            r_sec_idx  <= '0;
            r_sec_full <= 1'b0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (valid && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
          r_best_val <= w_best_val_nx;
          r_best_idx <= w_best_idx_nx;
          r_idx      <= r_idx + CNT_W'(1);
`ifdef TCB_ARGMAX_TOP2_EN
          r_sec_val  <= w_sec_val_nx;
          r_sec_idx  <= w_sec_idx_nx;
          r_sec_full <= 1'b1;
`endif
          if (r_idx == LAST_IDX) begin
            predict <= {{(32-CNT_W){1'b0}}, w_best_idx_nx};
            ready   <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
`ifdef TCB_ARGMAX_TOP2_EN
            predict2 <= {{(32-CNT_W){1'b0}}, w_sec_idx_nx};
            margin   <= w_best_ext - w_sec_ext;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tcb_argmax_seq.md
Name: tcb_argmax_seq

Overview:
- Parametrised sequential classifier output stage for the TCB network tops; successor to the fixed 10×27-bit combinational comparator.
- Accepts the final layer's score vector on a valid pulse and scans it one class per cycle.
- Emits the winning class index as a 32-bit `predict` with a one-cycle `ready` pulse.
- Adds signed/unsigned scoring, a busy indication, a dropped-frame counter and an optional top-2/margin output.

Parameters:
- N_CLASS, 10, number of class scores (≥2).
- SCORE_W, 27, width of each score.
- SCORE_SIGNED, 1, 1 = two's-complement scores; 0 = unsigned.
- DROP_W, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- layer_out  in  N_CLASS*SCORE_W  score vector; class k at bits [k*SCORE_W +: SCORE_W]
- valid  in  1  one-cycle pulse; layer_out is valid in this cycle
- predict  out  32  winning class index, zero-extended
- ready  out  1  one-cycle pulse; predict is valid from this cycle until the next result
- busy  out  1  high while a scan is in progress
- drop_cnt  out  DROP_W  count of valid pulses ignored while busy; saturating

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values: predict=0, ready=0, busy=0, drop_cnt=0, state=IDLE. The optional outputs also reset to 0.
- States:
  - IDLE: waiting for valid.
  - SCAN: comparing classes 1..N_CLASS-1.
  - DONE: asserting the result.
- IDLE + valid:
  - Latch the whole layer_out into an internal vector register.
  - best_val=score[0], best_idx=0, idx=1.
  - Go to SCAN; busy=1.
- SCAN, each cycle:
  - Compare score[idx] against best_val, signed or unsigned per SCORE_SIGNED.
  - Strictly greater: update best_val and best_idx.
  - Tie: keep the lower index.
  - idx increments. After comparing idx=N_CLASS-1, go to DONE.
- DONE, one cycle:
  - predict=best_idx, ready=1, busy=0.
  - Next state is IDLE.
  - A valid in the DONE cycle is accepted exactly as in IDLE, so back-to-back frames are supported.
- Latency: valid in cycle t gives ready in cycle t+N_CLASS. Throughput is one frame per N_CLASS cycles.
- valid while in SCAN:
  - Ignored; the latched vector is unchanged.
  - drop_cnt increments and saturates at all-ones.
- layer_out is not required to be held after the valid cycle.
- Between results, predict holds its last value; ready is low outside DONE.
- Reset mid-scan: abort immediately and apply the reset values. No ready pulse for the aborted frame.
- Index counter width: $clog2(N_CLASS).
- Compare width: SCORE_W+1. The extension bit is the sign bit when SCORE_SIGNED=1 and zero otherwise.

Optional Feature:
- Macro: TCB_ARGMAX_TOP2_EN.
- When defined, two extra outputs are present:
  - predict2 (32): second-best index.
  - margin (SCORE_W+1): best minus second-best, unsigned.
  - Both are registered alongside predict and valid in the same ready cycle.
- Second-best tracking during the scan:
  - When best is replaced, the old best moves to second.
  - Otherwise, second is replaced when score > second (strict).
  - Initial second=score[0] with index 0, marked empty; the first comparison always fills second.
- All classes equal: predict=0, predict2=1, margin=0.
- When undefined: the ports and logic are absent, and timing and behaviour are otherwise identical.

Decomposition:
- Package tcb_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - Function extend_score(val, signed_flag) returning SCORE_W+1 bits.
  - Localparam IDX_W=$clog2(N_CLASS).
- One natural sub-module: tcb_score_cmp. It is combinational: a (SCORE_W), b (SCORE_W), SCORE_SIGNED parameter, output gt. It is reused by the optional top-2 path.

Test Plan:
- Unsigned (SCORE_SIGNED=0), N_CLASS=10, scores k*5 except class 7=1000, valid at cycle 0 -> ready at cycle 10, predict=7, busy high cycles 1–9.
- Signed, scores all negative (-100..-91 for classes 0..9), max -91 at class 9 -> predict=9. Separately, class 3 = -1 with all others -1000 -> predict=3. Verifies no unsigned misinterpretation.
- Ties: classes 2 and 6 both 500, others 0 -> predict=2. Top-2 enabled: predict2=6, margin=0.
- Back-to-back: valid at cycles 0 and 10 with winners 4 and 8 -> ready at cycles 10 and 20, predict 4 then 8, drop_cnt=0. A valid at cycle 5 -> ignored, drop_cnt=1, frame-0 result unchanged.
- Reset at cycle 4 of a scan -> no ready, predict=0, busy=0. A new valid at cycle 6 -> ready at cycle 16 with the correct index.
- N_CLASS=2, SCORE_W=8 -> ready two cycles after valid. Scores {0x7F, 0x80} give predict=0 signed and predict=1 unsigned.
